// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receive front end: serial line to byte strobe with framing-error report
//
// Deserialises 8N1 frames (LSB first) from an asynchronous line into bytes.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling
// around each bit mid point; output pulses one cycle later).
//
// Ports:
//   clk          system clock, rising edge
//   clr_n        asynchronous active-low reset
//   rx           raw serial line, idles high
//   data[7:0]    last correctly framed byte
//   data_ready   one-cycle pulse when data is updated
//   framing_err  one-cycle pulse when a stop bit is sampled low
//   busy         high from start-bit detection until the return to IDLE
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       framing_err,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_MID  = 16'(CLKS_PER_BIT / 2);
`ifdef UART_RX_MAJORITY_EN
    // Decision is made one cycle after the mid point, once the third vote is in.
    localparam logic [15:0] CNT_DECIDE = CNT_MID + 16'd1;
`else
    localparam logic [15:0] CNT_DECIDE = CNT_MID;
`endif

    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_ready_q, data_ready_d;
    logic        framing_err_q, framing_err_d;

    logic        rx_s;
    logic        decide;
    logic        sample_bit;

    assign rx_s   = rx_s_q;
    assign decide = (bit_cnt_q == CNT_DECIDE);

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds rx_s from the previous cycle, hist_q[1] from two cycles ago,
    // so at CNT_DECIDE the three votes are mid-1, mid and mid+1.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d     = {hist_q[0], rx_s};
        sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        sample_bit = rx_s;
    end
`endif

    always_comb begin
        sync1_d       = rx;
        rx_s_d        = sync1_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_ready_d  = 1'b0;
        framing_err_d = 1'b0;

        // Bit periods are aligned to the start-bit edge: the counter wraps every
        // CLKS_PER_BIT cycles from cycle 0, so every sample lands at the same
        // phase (mid point) of its own bit.
        if (state_q != ST_IDLE) begin
            bit_cnt_d = (bit_cnt_q == CNT_LAST) ? 16'd0 : bit_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 16'd0;
                if (!rx_s) begin
                    // The detection cycle itself is count 0.
                    bit_cnt_d = 16'd1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (decide) begin
                    if (!sample_bit) begin
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {sample_bit, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (sample_bit) begin
                        data_d       = shift_q;
                        data_ready_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must go high before a new start is accepted.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 16'd0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            data_q        <= 8'h00;
            data_ready_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_ready_q  <= data_ready_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign data        = data_q;
    assign data_ready  = data_ready_q;
    assign framing_err = framing_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

    localparam int C = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Frame cycle of the output pulse, counted from the first IDLE cycle with rx_s low.
    localparam int LAT = C / 2 + 9 * C + 1 + MAJ;
    // Line bit driven at negedge before posedge P(k) is seen as rx_s in frame cycle k,
    // which the monitor observes at the negedge where cyc = drive cyc + k + 2.
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_ready;
    logic       framing_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .rx          (rx),
        .data        (data),
        .data_ready  (data_ready),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic       rdy;
        logic       ferr;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] tx;
        bit         stop_ok;
        logic [7:0] exp_d;
        bit         exp_ferr;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    logic wave[$];
    logic [7:0] model_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (data_ready || framing_err) begin
            e.t = cyc; e.rdy = data_ready; e.ferr = framing_err; e.d = data;
            obs_q.push_back(e);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    function automatic void check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    task automatic add_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endtask

    // stop_low = 0 gives a good stop bit; otherwise the line stays low that many
    // cycles from the start of the stop bit.
    task automatic add_frame(input logic [7:0] b, input int stop_low);
        repeat (C) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) wave.push_back(b[i]);
        if (stop_low == 0) repeat (C) wave.push_back(1'b1);
        else repeat (stop_low) wave.push_back(1'b0);
    endtask

    task automatic push_exp(input int base, input bit good, input logic [7:0] d);
        ev_t e;
        e.t = base + SYNC + LAT; e.rdy = good; e.ferr = !good; e.d = d;
        exp_q.push_back(e);
    endtask

    // Reference model: a good frame delivers its byte, a bad one repeats the last good byte.
    task automatic expect_frame(input int base, input bit good, input logic [7:0] b);
        if (good) model_data = b;
        push_exp(base, good, model_data);
    endtask

    task automatic run_wave(input int tail, input int exp_busy, input string tag);
        int  s0, ob0, b0, nobs;
        ev_t o;
        @(negedge clk);
        s0 = cyc; ob0 = obs_q.size(); b0 = busy_cnt;
        for (int j = 0; j < wave.size(); j++) begin
            if (j > 0) @(negedge clk);
            rx = wave[j];
        end
        rx = 1'b1;
        repeat (tail) @(negedge clk);
        nobs = obs_q.size() - ob0;
        check(nobs == exp_q.size(), {tag, "_event_count"}, nobs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
            o = obs_q[ob0 + i];
            check(o.t - s0 == exp_q[i].t, {tag, "_pulse_cycle"}, o.t - s0 - SYNC, exp_q[i].t - SYNC);
            check(o.rdy == exp_q[i].rdy, {tag, "_data_ready"}, int'(o.rdy), int'(exp_q[i].rdy));
            check(o.ferr == exp_q[i].ferr, {tag, "_framing_err"}, int'(o.ferr), int'(exp_q[i].ferr));
            check(o.d == exp_q[i].d, {tag, "_data"}, int'(o.d), int'(exp_q[i].d));
        end
        if (exp_busy >= 0) check(busy_cnt - b0 == exp_busy, {tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
        check(busy == 1'b0, {tag, "_busy_idle"}, int'(busy), 0);
        wave.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       vecs[8];
        int         base, base2, ob0, stop_len;
        logic [7:0] b;
        bit         good;

        vecs[0] = '{tx: 8'h88, stop_ok: 1'b1, exp_d: 8'h88, exp_ferr: 1'b0};
        vecs[1] = '{tx: 8'h00, stop_ok: 1'b1, exp_d: 8'h00, exp_ferr: 1'b0};
        vecs[2] = '{tx: 8'hFF, stop_ok: 1'b1, exp_d: 8'hFF, exp_ferr: 1'b0};
        vecs[3] = '{tx: 8'hA5, stop_ok: 1'b0, exp_d: 8'hFF, exp_ferr: 1'b1};
        vecs[4] = '{tx: 8'h5A, stop_ok: 1'b1, exp_d: 8'h5A, exp_ferr: 1'b0};
        vecs[5] = '{tx: 8'h01, stop_ok: 1'b1, exp_d: 8'h01, exp_ferr: 1'b0};
        vecs[6] = '{tx: 8'h80, stop_ok: 1'b0, exp_d: 8'h01, exp_ferr: 1'b1};
        vecs[7] = '{tx: 8'h7F, stop_ok: 1'b1, exp_d: 8'h7F, exp_ferr: 1'b0};

        // Reset values
        repeat (4) @(negedge clk);
        check(data == 8'h00, "reset_data", int'(data), 0);
        check(data_ready == 1'b0, "reset_data_ready", int'(data_ready), 0);
        check(framing_err == 1'b0, "reset_framing_err", int'(framing_err), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        clr_n = 1'b1;
        model_data = 8'h00;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        foreach (vecs[v]) begin
            add_idle(4);
            base = wave.size();
            add_frame(vecs[v].tx, vecs[v].stop_ok ? 0 : C + 5);
            add_idle(20);
            push_exp(base, !vecs[v].exp_ferr, vecs[v].exp_d);
            model_data = vecs[v].exp_d;
            run_wave(10, -1, "vector");
        end

        // Back-to-back frames, no idle gap
        add_idle(2);
        base = wave.size();
        add_frame(8'h40, 0);
        base2 = wave.size();
        add_frame(8'h88, 0);
        add_idle(20);
        expect_frame(base, 1'b1, 8'h40);
        expect_frame(base2, 1'b1, 8'h88);
        run_wave(10, 2 * (LAT - 1), "back_to_back");

        // False start then a good frame
        add_idle(2);
        repeat (4) wave.push_back(1'b0);
        add_idle(20);
        base = wave.size();
        add_frame(8'h3C, 0);
        add_idle(20);
        expect_frame(base, 1'b1, 8'h3C);
        run_wave(10, (C / 2 + MAJ) + (LAT - 1), "false_start");

        // Framing error with a held-low line, then recovery
        stop_len = C + 100;
        add_idle(2);
        base = wave.size();
        add_frame(8'h55, 0);
        expect_frame(base, 1'b1, 8'h55);
        add_idle(10);
        base = wave.size();
        add_frame(8'h12, stop_len);
        expect_frame(base, 1'b0, 8'h12);
        add_idle(10);
        base = wave.size();
        add_frame(8'hA1, 0);
        expect_frame(base, 1'b1, 8'hA1);
        add_idle(20);
        run_wave(10, (LAT - 1) + (9 * C + stop_len) + (LAT - 1), "framing");

        // One-cycle glitch exactly at the data bit 3 mid point
        add_idle(4);
        base = wave.size();
        add_frame(8'h00, 0);
        wave[base + C / 2 + 4 * C] = 1'b1;
        add_idle(20);
        expect_frame(base, 1'b1, (MAJ != 0) ? 8'h00 : 8'h08);
        run_wave(10, -1, "glitch");

        // Reset in the middle of data bit 4 of 0xFF
        add_idle(2);
        add_frame(8'hFF, 0);
        @(negedge clk);
        ob0 = obs_q.size();
        for (int j = 0; j < 2 + 5 * C + C / 2; j++) begin
            if (j > 0) @(negedge clk);
            rx = wave[j];
        end
        @(negedge clk);
        check(busy == 1'b1, "midframe_busy_before_reset", int'(busy), 1);
        clr_n = 1'b0;
        #1;
        check(data == 8'h00, "midframe_reset_data", int'(data), 0);
        check(busy == 1'b0, "midframe_reset_busy", int'(busy), 0);
        check(data_ready == 1'b0, "midframe_reset_data_ready", int'(data_ready), 0);
        check(framing_err == 1'b0, "midframe_reset_framing_err", int'(framing_err), 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        model_data = 8'h00;
        repeat (3 * C) @(negedge clk);
        check(obs_q.size() == ob0, "midframe_no_pulse", obs_q.size() - ob0, 0);
        wave.delete();
        add_idle(5);
        base = wave.size();
        add_frame(8'h7E, 0);
        add_idle(20);
        expect_frame(base, 1'b1, 8'h7E);
        run_wave(10, LAT - 1, "after_reset");

        // Randomized frames, gaps and framing errors against the reference model
        add_idle(2);
        for (int f = 0; f < 25; f++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            base = wave.size();
            add_frame(b, good ? 0 : C + int'($urandom_range(0, 30)));
            expect_frame(base, good, b);
            add_idle(good ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20)));
        end
        add_idle(20);
        run_wave(10, -1, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
